// File: rtl/sipo_collect.sv
// sipo_collect: serial-in parallel-out word collector.
// Bits are accepted under a valid/ready handshake until N have arrived.
// The completed word is then held under a valid/ready handshake until the
// consumer takes it.
module sipo_collect #(
  parameter int unsigned N     = 16,
  parameter int unsigned RIGHT = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clear,
  input  logic                       start,
  input  logic                       bit_in,
  input  logic                       bit_valid,
  output logic                       bit_ready,
  output logic [N-1:0]               out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(N+1)-1:0]     bit_count
);

  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    HOLD
  } state_t;

  state_t          state;
  logic [N-1:0]    sreg;
  logic [CW-1:0]   cnt;

  // FSM, shift register and bit counter; clear overrides every other input.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else if (clear) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= COLLECT;
            sreg  <= '0;
            cnt   <= '0;
          end
        end
        COLLECT: begin
          if (start) begin
            // Restart: any bit offered this cycle is dropped.
            sreg <= '0;
            cnt  <= '0;
          end else if (bit_valid) begin
            if (RIGHT != 0) begin
              sreg <= {bit_in, sreg[N-1:1]};
            end else begin
              sreg <= {sreg[N-2:0], bit_in};
            end
            cnt <= cnt + 1'b1;
            if (cnt == CW'(N - 1)) begin
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            if (start) begin
              state <= COLLECT;
              sreg  <= '0;
              cnt   <= '0;
            end else begin
              // Word and count stay visible in IDLE.
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          sreg  <= '0;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Handshake flags decode registered state only.
  always_comb begin
    bit_ready = (state == COLLECT);
    out_valid = (state == HOLD);
    out       = sreg;
    bit_count = cnt;
  end

endmodule

// File: tb/tb_sipo_collect.sv
// tb_sipo_collect: two N=8 collectors (LSB-first and MSB-first) share one
// stimulus stream and are compared against a queue-based model of the
// accepted bits.
module tb_sipo_collect;

  localparam int unsigned N = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         clear, start, bit_in, bit_valid, out_ready;
  logic         rdy_r, rdy_l, ov_r, ov_l;
  logic [N-1:0] out_r, out_l;
  logic [3:0]   bc_r, bc_l;

  int unsigned  n_vec  = 0;
  int unsigned  n_miss = 0;

  // Model: phase 0 = idle, 1 = collecting, 2 = holding.
  int           m_phase;
  logic         m_bits[$];

  always #5 clk = ~clk;

  sipo_collect #(.N(N), .RIGHT(1)) dut_r (
    .clk(clk), .reset_n(reset_n), .clear(clear), .start(start),
    .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(rdy_r),
    .out(out_r), .out_valid(ov_r), .out_ready(out_ready), .bit_count(bc_r)
  );

  sipo_collect #(.N(N), .RIGHT(0)) dut_l (
    .clk(clk), .reset_n(reset_n), .clear(clear), .start(start),
    .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(rdy_l),
    .out(out_l), .out_valid(ov_l), .out_ready(out_ready), .bit_count(bc_l)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected word from the list of accepted bits, oldest first.
  function automatic logic [N-1:0] exp_word(input bit lsb_first);
    logic [N-1:0] w;
    int k;
    w = '0;
    k = m_bits.size();
    for (int j = 0; j < k; j++) begin
      if (lsb_first) w[N - k + j] = m_bits[j];
      else           w[k - 1 - j] = m_bits[j];
    end
    return w;
  endfunction

  function automatic void model_step(input logic c, input logic s, input logic bv,
                                     input logic bi, input logic ordy);
    if (c) begin
      m_phase = 0;
      m_bits.delete();
    end else if (m_phase == 0) begin
      if (s) begin
        m_phase = 1;
        m_bits.delete();
      end
    end else if (m_phase == 1) begin
      if (s) begin
        m_bits.delete();
      end else if (bv) begin
        m_bits.push_back(bi);
        if (m_bits.size() == N) m_phase = 2;
      end
    end else begin
      if (ordy) begin
        if (s) begin
          m_phase = 1;
          m_bits.delete();
        end else begin
          m_phase = 0;
        end
      end
    end
  endfunction

  function automatic void model_reset();
    m_phase = 0;
    m_bits.delete();
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".out_r"},  32'(out_r), 32'(exp_word(1'b1)));
    chk({tag, ".out_l"},  32'(out_l), 32'(exp_word(1'b0)));
    chk({tag, ".cnt_r"},  32'(bc_r),  32'(m_bits.size()));
    chk({tag, ".cnt_l"},  32'(bc_l),  32'(m_bits.size()));
    chk({tag, ".rdy_r"},  32'(rdy_r), 32'(m_phase == 1));
    chk({tag, ".rdy_l"},  32'(rdy_l), 32'(m_phase == 1));
    chk({tag, ".ov_r"},   32'(ov_r),  32'(m_phase == 2));
    chk({tag, ".ov_l"},   32'(ov_l),  32'(m_phase == 2));
  endtask

  // One clock: drive, apply the edge to the model, check 1 time unit later.
  task automatic cyc(input string tag, input logic c, input logic s, input logic bv,
                     input logic bi, input logic ordy);
    clear = c; start = s; bit_valid = bv; bit_in = bi; out_ready = ordy;
    @(posedge clk);
    model_step(c, s, bv, bi, ordy);
    #1;
    check_all(tag);
  endtask

  // Mid-cycle asynchronous reset pulse; outputs must drop before any edge.
  task automatic async_reset(input string tag);
    #3;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all({tag, ".in_rst"});
    #2;
    reset_n = 1'b1;
    #1;
    check_all({tag, ".rel"});
  endtask

  logic [7:0] pat;

  initial begin
    pat = 8'b0100_1101;   // bits sent oldest first: 1,0,1,1,0,0,1,0
    reset_n = 1'b0;
    clear = 1'b0; start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; out_ready = 1'b0;
    model_reset();
    #2;
    check_all("reset");
    #11;
    reset_n = 1'b1;

    // Idle ignores bits.
    cyc("idle_bv", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Scenarios 1 and 2: consecutive bits.
    cyc("s1_start", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cyc("s1_bit", 1'b0, 1'b0, 1'b1, pat[i], 1'b0);
    chk("s1_word_r", 32'(out_r), 32'h4D);
    chk("s2_word_l", 32'(out_l), 32'hB2);
    chk("s1_valid",  32'(ov_r),  32'd1);
    chk("s1_count",  32'(bc_r),  32'd8);

    // Consumer takes it without start: idle with word retained.
    cyc("take", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("take_keep", 32'(out_r), 32'h4D);

    // Scenario 3: bit_valid on alternate cycles.
    cyc("s3_start", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cyc("s3_gap", 1'b0, 1'b0, 1'b0, ~pat[i], 1'b0);
      cyc("s3_bit", 1'b0, 1'b0, 1'b1, pat[i], 1'b0);
    end
    chk("s3_word", 32'(out_r), 32'h4D);

    // Scenario 4: stall in hold with bits and start pulses, then ready+start.
    for (int i = 0; i < 5; i++) cyc("s4_stall", 1'b0, i[0], 1'b1, 1'b1, 1'b0);
    chk("s4_hold", 32'(out_l), 32'hB2);
    cyc("s4_rs", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("s4_cnt0", 32'(bc_r), 32'd0);
    chk("s4_rdy",  32'(rdy_r), 32'd1);

    // Restart in collect drops the bit offered alongside start.
    cyc("rs_bit", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc("rs_restart", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

    // Scenario 5: clear with start after 3 bits.
    for (int i = 0; i < 3; i++) cyc("s5_bit", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc("s5_clear", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("s5_out0", 32'(out_r), 32'd0);

    // Scenario 6: asynchronous reset after 5 bits.
    cyc("s6_start", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc("s6_bit", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    async_reset("s6");
    cyc("s6_after", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        async_reset("rnd_rst");
      end else begin
        cyc("rnd",
            ($urandom_range(0, 63) == 0),
            ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 9) < 6),
            1'($urandom),
            ($urandom_range(0, 9) < 3));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/sipo_collect.md
SIPO_COLLECT -- requirements
Module: sipo_collect

Interface
REQ-001 Parameter N, default 16: width of the collected word; the legal range is N >= 2.
REQ-002 Parameter RIGHT, default 1: 1 = LSB-first collection, with bits entering at the MSB and shifting right; 0 = MSB-first collection, with bits entering at the LSB and shifting left.
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  reset; asynchronous, active-low.
REQ-005 clear  input  1  synchronous abort: return to IDLE and zero the datapath.
REQ-006 start  input  1  begin collecting a new word.
REQ-007 bit_in  input  1  serial data bit.
REQ-008 bit_valid  input  1  bit_in is valid this cycle.
REQ-009 bit_ready  output  1  the block accepts bit_in this cycle; high only in COLLECT.
REQ-010 out  output  N  parallel collected word.
REQ-011 out_valid  output  1  out holds a complete word; high only in HOLD.
REQ-012 out_ready  input  1  consumer accepts out this cycle.
REQ-013 bit_count  output  clog2(N+1)  number of bits accepted in the current word.

Function
REQ-014 The block SHALL implement a three-state FSM: IDLE, COLLECT and HOLD.
REQ-015 A bit SHALL be accepted only on a cycle with bit_valid & bit_ready, and only when clear and start are both low.
REQ-016 In IDLE, start SHALL cause the next state to be COLLECT, with the shift register zeroed and bit_count = 0; bit_valid SHALL be ignored in IDLE.
REQ-017 On each accepted bit with RIGHT=1, the shift register SHALL update as reg = {bit_in, reg[N-1:1]}.
REQ-018 On each accepted bit with RIGHT=0, the shift register SHALL update as reg = {reg[N-2:0], bit_in}.
REQ-019 Each accepted bit SHALL increment bit_count by 1.
REQ-020 A cycle in COLLECT without an accepted bit SHALL hold the shift register and bit_count unchanged.
REQ-021 The Nth accepted bit SHALL move the FSM to HOLD, with bit_count = N and out_valid = 1 on the following cycle; the latency from the last bit to out_valid is one cycle.
REQ-022 out SHALL equal the shift register at all times.
REQ-023 In HOLD, out, out_valid and bit_count SHALL remain stable until out_ready is sampled high.
REQ-024 In HOLD, bit_valid SHALL be ignored.
REQ-025 In HOLD, out_ready without start SHALL return the FSM to IDLE, leaving out holding the last word and bit_count = N.
REQ-026 In HOLD, out_ready together with start SHALL move the FSM directly to COLLECT, with the register zeroed and bit_count = 0.
REQ-027 In HOLD, start without out_ready SHALL be ignored.
REQ-028 start in COLLECT SHALL restart collection: register zeroed, bit_count = 0, state remains COLLECT, and any bit presented in that cycle is discarded.
REQ-029 clear SHALL have the highest priority: from any state the next state is IDLE, with the register zeroed and bit_count = 0, overriding start, bit_valid and out_ready.
REQ-030 bit_ready and out_valid SHALL be decoded from registered state only and SHALL have no combinational path from any input.

Reset
REQ-031 While reset_n is low, the block SHALL immediately force the FSM to IDLE and drive out = 0, bit_count = 0, out_valid = 0 and bit_ready = 0, regardless of clk.
REQ-032 Deassertion of reset_n mid-word SHALL leave the block in IDLE; the partial word is lost and a new start is required.

Verification
REQ-033 Scenario 1: N=8, RIGHT=1; start, then bits 1,0,1,1,0,0,1,0 on consecutive cycles -> one cycle after the 8th bit, out_valid=1, out=8'h4D, bit_count=8.
REQ-034 Scenario 2: N=8, RIGHT=0; the same bit sequence -> out=8'hB2, out_valid=1.
REQ-035 Scenario 3: N=8, RIGHT=1; bit_valid toggled every other cycle, the same 8 bits -> out=8'h4D; bit_count increments only on valid cycles.
REQ-036 Scenario 4: word complete, out_ready held low for 5 cycles while bit_valid=1 and start pulses -> out, out_valid and bit_count unchanged; then out_ready and start asserted together -> next cycle state is COLLECT with bit_count=0 and out=0.
REQ-037 Scenario 5: clear asserted after 3 bits, with start=1 in the same cycle -> next cycle IDLE, out=0, bit_count=0, bit_ready=0.
REQ-038 Scenario 6: reset_n pulsed low asynchronously between clock edges after 5 bits -> out=0 and bit_count=0 immediately, out_valid=0; block in IDLE after release.
